// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and helpers for the multi-lane flushable FIFO.
// Provides the lane-slice macro, a clog2-style constant function for the
// lane-count widths and the depth derivation from the address width.
`ifndef FIFO_LANE
`define FIFO_LANE(i, w) (i)*(w) +: (w)
`endif

package fifo_pkg;

  // Number of bits needed to encode values 0..n-1 (minimum 0).
  function automatic int fifo_clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Storage depth derived from the pointer address width.
  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/fifo_mp_ram.sv
// fifo_mp_ram: DEPTH x DATA_LEN storage with WR_PORTS write lanes and
// RD_PORTS asynchronous read lanes. Lane i addresses base+i, wrapping mod
// DEPTH. Storage is deliberately not reset.
`ifndef FIFO_LANE
`define FIFO_LANE(i, w) (i)*(w) +: (w)
`endif

module fifo_mp_ram
  import fifo_pkg::*;
#(
  parameter int DATA_LEN   = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int WR_PORTS   = 2,
  parameter int RD_PORTS   = 2
) (
  input  logic                         clk,
  input  logic [WR_PORTS-1:0]          we_i,
  input  logic [ADDR_WIDTH-1:0]        waddr_i,
  input  logic [WR_PORTS*DATA_LEN-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0]        raddr_i,
  output logic [RD_PORTS*DATA_LEN-1:0] rdata_o
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_LEN-1:0] mem_q [DEPTH];

  // Write each enabled lane to consecutive addresses starting at the base.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WR_PORTS; i++) begin
      if (we_i[i]) begin
        mem_q[waddr_i + ADDR_WIDTH'(i)] <= wdata_i[`FIFO_LANE(i, DATA_LEN)];
      end
    end
  end

  // Present consecutive entries from the read base on the read lanes.
  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < RD_PORTS; i++) begin
      rdata_o[`FIFO_LANE(i, DATA_LEN)] = mem_q[raddr_i + ADDR_WIDTH'(i)];
    end
  end

endmodule

// File: rtl/fifo_mp_flush.sv
// fifo_mp_flush: multi-lane FIFO with flush, used as the instruction buffer
// between fetch and decode. Up to WR_PORTS pushes and RD_PORTS pops per
// cycle with all-or-nothing acceptance; flush discards every entry.
// Optional macro FIFO_MP_ERR_EN enables the sticky overflow/underflow flag
// err; without it err is tied low.
`ifndef FIFO_LANE
`define FIFO_LANE(i, w) (i)*(w) +: (w)
`endif

module fifo_mp_flush
  import fifo_pkg::*;
#(
  parameter int DATA_LEN     = 32,
  parameter int ADDR_WIDTH   = 4,
  parameter int WR_PORTS     = 2,
  parameter int RD_PORTS     = 2,
  parameter int AFULL_THRESH = fifo_depth(ADDR_WIDTH) - 2,
  localparam int DEPTH       = fifo_depth(ADDR_WIDTH),
  localparam int WN_W        = fifo_clog2(WR_PORTS + 1),
  localparam int RN_W        = fifo_clog2(RD_PORTS + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [WN_W-1:0]              wr_num,
  input  logic [WR_PORTS*DATA_LEN-1:0] wdata,
  input  logic [RN_W-1:0]              rd_num,
  output logic [RD_PORTS*DATA_LEN-1:0] rdata,
  output logic [RN_W-1:0]              rd_avail,
  output logic [ADDR_WIDTH:0]          count,
  output logic [ADDR_WIDTH:0]          free,
  output logic                         empty,
  output logic                         full,
  output logic                         almost_full,
  output logic                         err
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic                wr_ok, rd_ok, wr_fire;
  logic [WR_PORTS-1:0] lane_we;

  // The extra pointer bit distinguishes full from empty.
  assign count       = wr_ptr_q - rd_ptr_q;
  assign free        = PW'(DEPTH) - count;
  assign empty       = (count == '0);
  assign full        = (count == PW'(DEPTH));
  assign almost_full = (int'(count) >= AFULL_THRESH);

  // Readable lanes: the stored count, capped at the number of read lanes.
  always_comb begin
    if (int'(count) >= RD_PORTS) begin
      rd_avail = RN_W'(RD_PORTS);
    end else begin
      rd_avail = RN_W'(count);
    end
  end

  // All-or-nothing acceptance judged on pre-edge occupancy; a same-cycle
  // read never makes room for a write, nor can a write be read back.
  assign wr_ok   = (int'(wr_num) <= WR_PORTS) && (int'(wr_num) <= int'(free));
  assign rd_ok   = (rd_num <= rd_avail);
  assign wr_fire = !flush && wr_ok && (wr_num != '0);

  // Enable the first wr_num lanes of an accepted write.
  always_comb begin
    lane_we = '0;
    for (int i = 0; i < WR_PORTS; i++) begin
      lane_we[i] = wr_fire && (i < int'(wr_num));
    end
  end

  // Pointer advance; flush collapses the write pointer onto the read pointer.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = rd_ptr_q;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + PW'(wr_num);
      if (rd_ok) rd_ptr_d = rd_ptr_q + PW'(rd_num);
    end
  end

  // Pointer registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

`ifdef FIFO_MP_ERR_EN
  logic err_q, err_d;

  // Sticky flag: any rejected non-zero request outside a flush sets it.
  always_comb begin
    err_d = err_q;
    if (!flush && (!wr_ok || !rd_ok)) err_d = 1'b1;
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  fifo_mp_ram #(
    .DATA_LEN   (DATA_LEN),
    .ADDR_WIDTH (ADDR_WIDTH),
    .WR_PORTS   (WR_PORTS),
    .RD_PORTS   (RD_PORTS)
  ) u_ram (
    .clk     (clk),
    .we_i    (lane_we),
    .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata_o (rdata)
  );

endmodule

// File: tb/tb_fifo_mp_flush.sv
// tb_fifo_mp_flush: directed bench for fifo_mp_flush (defaults: 16 deep,
// 2 write / 2 read lanes). A queue-based model tracks the expected contents
// and a negedge compare process checks every output each cycle.
module tb_fifo_mp_flush;

`ifdef FIFO_MP_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [1:0]  wr_num = '0;
  logic [63:0] wdata = '0;
  logic [1:0]  rd_num = '0;
  logic [63:0] rdata;
  logic [1:0]  rd_avail;
  logic [4:0]  count;
  logic [4:0]  free;
  logic        empty, full, almost_full, err;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  fifo_mp_flush dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .wr_num      (wr_num),
    .wdata       (wdata),
    .rd_num      (rd_num),
    .rdata       (rdata),
    .rd_avail    (rd_avail),
    .count       (count),
    .free        (free),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of stored words plus the sticky error bit.
  logic [31:0] mq[$];
  bit          err_m = 1'b0;

  always @(posedge clk or posedge rst) begin
    int sz;
    int av;
    bit wok;
    bit rok;
    if (rst) begin
      mq.delete();
      err_m = 1'b0;
    end else if (flush) begin
      mq.delete();
    end else begin
      sz  = mq.size();
      av  = (sz < 2) ? sz : 2;
      wok = (int'(wr_num) <= 2) && (int'(wr_num) <= 16 - sz);
      rok = (int'(rd_num) <= av);
      if (!wok || !rok) err_m = 1'b1;
      if (rok) repeat (int'(rd_num)) void'(mq.pop_front());
      if (wok) for (int i = 0; i < int'(wr_num); i++) mq.push_back(wdata[i*32 +: 32]);
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    int sz;
    if (chk_en) begin
      sz = mq.size();
      check("count", 64'(count), 64'(sz));
      check("free", 64'(free), 64'(16 - sz));
      check("empty", 64'(empty), 64'(sz == 0));
      check("full", 64'(full), 64'(sz == 16));
      check("almost_full", 64'(almost_full), 64'(sz >= 14));
      check("rd_avail", 64'(rd_avail), 64'((sz < 2) ? sz : 2));
      check("err", 64'(err), 64'(ERR_ON & err_m));
      if (sz >= 1) check("rdata0", 64'(rdata[31:0]), 64'(mq[0]));
      if (sz >= 2) check("rdata1", 64'(rdata[63:32]), 64'(mq[1]));
    end
  end

  task automatic cyc(input int wn, input logic [31:0] d0, input logic [31:0] d1,
                     input int rn, input logic fl);
    wr_num = 2'(wn);
    wdata  = {d1, d0};
    rd_num = 2'(rn);
    flush  = fl;
    @(posedge clk);
    #1;
    wr_num = '0;
    rd_num = '0;
    flush  = 1'b0;
  endtask

  task automatic rst_pulse();
    #1 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  initial begin
    #12 rst = 1'b0;
    chk_en = 1'b1;
    // Reset state
    check("rst_count", 64'(count), 64'd0);
    check("rst_free", 64'(free), 64'd16);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_afull", 64'(almost_full), 64'd0);
    check("rst_avail", 64'(rd_avail), 64'd0);
    check("rst_err", 64'(err), 64'd0);

    // Fill to full
    for (int k = 0; k < 8; k++) begin
      cyc(2, 32'hA0 + 32'(2*k), 32'hA1 + 32'(2*k), 0, 1'b0);
      check("fill_count", 64'(count), 64'(2*k + 2));
      if (k == 5) check("afull_at12", 64'(almost_full), 64'd0);
      if (k == 6) check("afull_at14", 64'(almost_full), 64'd1);
    end
    check("full_flag", 64'(full), 64'd1);
    check("full_free", 64'(free), 64'd0);
    cyc(1, 32'hEE, 32'h0, 0, 1'b0);
    check("ovf_count", 64'(count), 64'd16);
    check("ovf_err", 64'(err), 64'(ERR_ON));
    check("ovf_lane0", 64'(rdata[31:0]), 64'hA0);
    check("ovf_lane1", 64'(rdata[63:32]), 64'hA1);

    // Underflow on empty
    rst_pulse();
    check("rst2_err", 64'(err), 64'd0);
    cyc(0, 32'h0, 32'h0, 1, 1'b0);
    check("udf0_count", 64'(count), 64'd0);
    check("udf0_err", 64'(err), 64'(ERR_ON));
    rst_pulse();

    // Wrap: 15 stored at write index 15
    for (int k = 0; k < 7; k++) cyc(2, 32'hB0 + 32'(2*k), 32'hB1 + 32'(2*k), 0, 1'b0);
    cyc(1, 32'hBE, 32'h0, 0, 1'b0);
    check("wrap_count15", 64'(count), 64'd15);
    cyc(2, 32'hC0, 32'hC1, 2, 1'b0);
    check("wrap_count13", 64'(count), 64'd13);
    check("wrap_head", 64'(rdata[31:0]), 64'hB2);
    check("wrap_err", 64'(err), 64'(ERR_ON));
    cyc(2, 32'hC0, 32'hC1, 0, 1'b0);
    check("wrap_count15b", 64'(count), 64'd15);
    repeat (6) cyc(0, 32'h0, 32'h0, 2, 1'b0);
    check("wrap_lane0", 64'(rdata[31:0]), 64'hBE);
    check("wrap_lane1", 64'(rdata[63:32]), 64'hC0);
    cyc(0, 32'h0, 32'h0, 2, 1'b0);
    check("wrap_c1", 64'(rdata[31:0]), 64'hC1);

    // Underflow at count 1
    cyc(0, 32'h0, 32'h0, 2, 1'b0);
    check("udf_count", 64'(count), 64'd1);
    check("udf_lane0", 64'(rdata[31:0]), 64'hC1);
    cyc(0, 32'h0, 32'h0, 1, 1'b0);
    check("drain_empty", 64'(empty), 64'd1);

    // Flush
    for (int k = 0; k < 4; k++) cyc(2, 32'hD0 + 32'(2*k), 32'hD1 + 32'(2*k), 0, 1'b0);
    cyc(1, 32'hD8, 32'h0, 0, 1'b0);
    check("pre_flush", 64'(count), 64'd9);
    cyc(2, 32'hE0, 32'hE1, 1, 1'b1);
    check("flush_count", 64'(count), 64'd0);
    check("flush_empty", 64'(empty), 64'd1);
    check("flush_err", 64'(err), 64'(ERR_ON));
    cyc(1, 32'h55, 32'h0, 0, 1'b0);
    check("post_flush_d", 64'(rdata[31:0]), 64'h55);
    check("post_flush_av", 64'(rd_avail), 64'd1);

    // Asynchronous reset between edges
    for (int k = 0; k < 3; k++) cyc(2, 32'h60 + 32'(2*k), 32'h61 + 32'(2*k), 0, 1'b0);
    check("pre_arst", 64'(count), 64'd7);
    #1 rst = 1'b1;
    #1;
    check("arst_count", 64'(count), 64'd0);
    check("arst_empty", 64'(empty), 64'd1);
    check("arst_free", 64'(free), 64'd16);
    check("arst_err", 64'(err), 64'd0);
    #1 rst = 1'b0;

    // wr_num beyond lane count is an overflow
    cyc(3, 32'h70, 32'h71, 0, 1'b0);
    check("wn3_count", 64'(count), 64'd0);
    check("wn3_err", 64'(err), 64'(ERR_ON));

    // Concurrent accepted read and write
    cyc(2, 32'h11, 32'h22, 0, 1'b0);
    cyc(1, 32'h33, 32'h0, 1, 1'b0);
    check("rw_count", 64'(count), 64'd2);
    check("rw_lane0", 64'(rdata[31:0]), 64'h22);
    check("rw_lane1", 64'(rdata[63:32]), 64'h33);

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_mp_flush.md
Name: fifo_mp_flush

Overview:
- Parametrised multi-lane FIFO with flush, the successor to the single-lane flushable FIFO.
- Accepts up to WR_PORTS entries and releases up to RD_PORTS entries per cycle.
- Provides occupancy and free-space counts, an almost-full threshold, and all-or-nothing over/underflow protection.
- Sits between IFU and IDU as the instruction buffer for 2-wide fetch/decode; flush on redirect discards all entries.

Parameters:
- DATA_LEN, 32, bits per entry.
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH, minimum 2.
- WR_PORTS, 2, write lanes; range 1..DEPTH.
- RD_PORTS, 2, read lanes; range 1..DEPTH.
- AFULL_THRESH, DEPTH-2, almost_full asserts when count >= AFULL_THRESH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  discard all stored entries.
- wr_num  in  WN_W=$clog2(WR_PORTS+1)  number of valid write lanes; lanes 0..wr_num-1 are used.
- wdata  in  WR_PORTS*DATA_LEN  lane i at bits [i*DATA_LEN +: DATA_LEN]; lane 0 is the oldest.
- rd_num  in  RN_W=$clog2(RD_PORTS+1)  number of entries consumed this cycle.
- rdata  out  RD_PORTS*DATA_LEN  lane i = entry at rd_ptr+i; lane 0 is the head.
- rd_avail  out  RN_W  min(count, RD_PORTS); lanes >= rd_avail are don't-care.
- count  out  ADDR_WIDTH+1  stored entries, 0..DEPTH.
- free  out  ADDR_WIDTH+1  DEPTH-count.
- empty, full, almost_full  out  1 each.
- err  out  1  sticky overflow/underflow flag (see Optional Feature).

Behaviour:
- **Pointers:** wr_ptr and rd_ptr are ADDR_WIDTH+1 bits and wrap naturally mod 2*DEPTH. count = wr_ptr - rd_ptr. Storage is indexed by ptr[ADDR_WIDTH-1:0], so lane addresses wrap mod DEPTH.
- **Reset (async, rst=1):** wr_ptr=rd_ptr=0, so count=0, free=DEPTH, empty=1, full=0, almost_full=0 (with default threshold), rd_avail=0, err=0. Storage is not reset.
- **Outputs:** all combinational from pointers and storage. Read latency is zero: the head is visible while stored. Data written at edge N is readable after edge N.
- **Write acceptance:** accepted iff wr_num <= free, evaluated against pre-edge count. Same-cycle reads do not create space.
  - Accepted: lane i is written to wr_ptr+i for i < wr_num, and wr_ptr += wr_num.
  - Rejected: nothing is written and wr_ptr holds (overflow event).
  - wr_num > WR_PORTS is treated as an overflow event.
- **Read acceptance:** accepted iff rd_num <= rd_avail.
  - Accepted: rd_ptr += rd_num.
  - Rejected: rd_ptr holds (underflow event). Same-cycle writes cannot be read.
- **Independence:** write and read are judged independently in the same cycle. Both may be accepted: count_next = count + wr_num - rd_num.
- **Flush priority:** flush=1 overrides both. wr_ptr <= rd_ptr, no storage write, no read, no err update. After the edge, count=0 and empty=1.
- **Zero requests:** wr_num=0 and rd_num=0 are no-ops; they are not events.
- **Reset mid-transfer:** all in-flight requests are lost and state matches the reset values at once.

Optional Feature:
- Macro: FIFO_MP_ERR_EN.
- When defined, err is set at the edge of any overflow or underflow event (flush=0). It clears only on rst.
- When undefined, err is tied 0 and no error logic is generated. Acceptance rules are unchanged either way.

Decomposition:
- Shared package/header fifo_pkg holds:
  - a clog2-style constant function for WN_W/RN_W;
  - lane-slice helper macros;
  - the DEPTH derivation.
- One natural sub-module, fifo_mp_ram: the DEPTH x DATA_LEN array with WR_PORTS write ports and RD_PORTS asynchronous read ports, addresses mod DEPTH.
- Pointer, count and acceptance logic stay in the top module.

Test Plan:
Defaults DEPTH=16, 2/2 lanes.
1. **Reset:** release rst -> count=0, free=16, empty=1, rd_avail=0, err=0.
2. **Fill:** wr_num=2 with 0xA0+k for 8 cycles -> count=16, full=1, almost_full=1 from count 14. A further wr_num=1 is rejected: count stays 16, err=1 under macro.
3. **Wrap:** 15 entries stored; simultaneous rd_num=2 and wr_num=2 -> write rejected (free=1), read accepted, count=13. The next cycle wr_num=2 is accepted and lanes straddle index 15->0, read back in order.
4. **Underflow:** count=1, rd_num=2 -> rejected, rd_ptr unchanged, rdata lane0 unchanged, err=1 under macro.
5. **Flush:** count=9; flush=1 with wr_num=2, rd_num=1 -> next cycle count=0, empty=1, err unchanged. A subsequent wr_num=1 of 0x55 -> rdata lane0=0x55, rd_avail=1.
6. **Async reset mid-stream:** rst pulses between edges at count=7 -> count=0 immediately, without waiting for clk.
